// File: rtl/iob_scatter_pkg.sv
// Shared constants, state encoding and lane-packing helpers for the L2-to-CU-bank scatter path.
package iob_scatter_pkg;

    localparam int BANK_NUM   = 32;
    localparam int BANK_DW    = 32;
    localparam int L2_DW      = 256;
    localparam int HALF_LANES = BANK_NUM / 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HALF = 1'b1
    } scatter_state_e;

    // Byte lane of a beat, zero-extended to a bank word.
    function automatic logic [BANK_DW-1:0] unpack8(input logic [L2_DW-1:0] data, input int lane);
        unpack8 = {24'h000000, data[8*lane +: 8]};
    endfunction

    // Halfword lane of a beat, zero-extended to a bank word.
    function automatic logic [BANK_DW-1:0] unpack16(input logic [L2_DW-1:0] half, input int lane);
        unpack16 = {16'h0000, half[16*lane +: 16]};
    endfunction

endpackage

// File: rtl/iob_scatter.sv
// Unpacks 256-bit L2 beats into 32 per-bank write lanes (int8: one beat, int16: two beats)
// behind a single registered output entry with valid/ready on both sides.
module iob_scatter
    import iob_scatter_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               iob_pric,
    input  logic                               l2c_datain_vld,
    input  logic                               l2c_datain_last,
    output logic                               l2c_datain_rdy,
    input  logic [L2_DW-1:0]                   l2c_datain_data,
    output logic [BANK_NUM-1:0][BANK_DW-1:0]   CU_bank_data_in,
    output logic [BANK_NUM-1:0]                CU_bank_data_in_vld,
    output logic [BANK_NUM-1:0]                CU_bank_data_in_last,
    input  logic [BANK_NUM-1:0]                CU_bank_data_in_ready,
    output logic                               odd_last_err
);

    scatter_state_e                    r_state;
    logic [L2_DW-1:0]                  r_stage;
    logic                              r_pric;
    logic [BANK_NUM-1:0][BANK_DW-1:0]  r_data;
    logic [BANK_NUM-1:0]               r_vld;
    logic [BANK_NUM-1:0]               r_last;
    logic                              r_odd;

    logic                              w_out_any;
    logic                              w_out_fire;
    logic                              w_in_fire;
    logic                              w_int16;
    logic                              w_load;
    logic                              w_odd;
    logic                              w_stage_en;
    logic [BANK_NUM-1:0][BANK_DW-1:0]  w_nxt_data;
    logic [BANK_NUM-1:0]               w_nxt_vld;
    logic [BANK_NUM-1:0]               w_nxt_last;

    // Handshake: banks with vld=0 never hold the entry back.
    always_comb begin
        w_out_any      = |r_vld;
        w_out_fire     = w_out_any & (&(CU_bank_data_in_ready | ~r_vld));
        l2c_datain_rdy = ~w_out_any | w_out_fire;
        w_in_fire      = l2c_datain_vld & l2c_datain_rdy;
        // Inside a group the mode latched at its first beat wins over the live input.
        w_int16        = (r_state == HALF) ? r_pric : iob_pric;
    end

    // Next output entry and group-completion decode for the current beat.
    always_comb begin
        w_nxt_data = '0;
        w_nxt_vld  = '0;
        w_nxt_last = '0;
        w_load     = 1'b0;
        w_odd      = 1'b0;
        w_stage_en = 1'b0;
        if (!w_int16) begin
            for (int j = 0; j < BANK_NUM; j++) begin
                w_nxt_data[j] = unpack8(l2c_datain_data, j);
            end
            w_nxt_vld  = '1;
            w_nxt_last = {BANK_NUM{l2c_datain_last}};
            w_load     = w_in_fire;
        end else if (r_state == HALF) begin
            for (int j = 0; j < HALF_LANES; j++) begin
                w_nxt_data[j]              = unpack16(r_stage, j);
                w_nxt_data[j + HALF_LANES] = unpack16(l2c_datain_data, j);
            end
            w_nxt_vld  = '1;
            w_nxt_last = {BANK_NUM{l2c_datain_last}};
            w_load     = w_in_fire;
        end else if (l2c_datain_last) begin
            // Transfer ended on the first beat of a pair: only the lower banks get data.
            for (int j = 0; j < HALF_LANES; j++) begin
                w_nxt_data[j] = unpack16(l2c_datain_data, j);
            end
            w_nxt_vld  = {{HALF_LANES{1'b0}}, {HALF_LANES{1'b1}}};
            w_nxt_last = {{HALF_LANES{1'b0}}, {HALF_LANES{1'b1}}};
            w_load     = w_in_fire;
            w_odd      = w_in_fire;
        end else begin
            w_stage_en = w_in_fire;
        end
    end

    // Pairing state, staging register and the registered output entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_stage <= '0;
            r_pric  <= 1'b0;
            r_data  <= '0;
            r_vld   <= '0;
            r_last  <= '0;
            r_odd   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_stage_en) begin
                        r_state <= HALF;
                        r_stage <= l2c_datain_data;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                HALF: begin
                    if (w_in_fire) begin
                        r_state <= IDLE;
                    end else begin
                        r_state <= HALF;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_in_fire && (r_state == IDLE)) begin
                r_pric <= iob_pric;
            end else begin
                r_pric <= r_pric;
            end

            // A completing beat reloads the entry in the same edge the old one drains.
            if (w_load) begin
                r_data <= w_nxt_data;
                r_vld  <= w_nxt_vld;
                r_last <= w_nxt_last;
            end else if (w_out_fire) begin
                r_vld  <= '0;
                r_last <= '0;
            end else begin
                r_vld  <= r_vld;
                r_last <= r_last;
            end

            r_odd <= w_odd;
        end
    end

    assign CU_bank_data_in      = r_data;
    assign CU_bank_data_in_vld  = r_vld;
    assign CU_bank_data_in_last = r_last;
    assign odd_last_err         = r_odd;

endmodule

// File: tb/tb_iob_scatter.sv
// Self-checking bench for iob_scatter: directed vector table, hand-written corner sequences,
// then randomized traffic against a group-level reference model.
module tb_iob_scatter;
    import iob_scatter_pkg::*;

    typedef logic [31:0][31:0] bank_t;

    typedef struct {
        logic         pric;
        logic         last;
        logic [255:0] data;
        logic [31:0]  exp_vld;
        logic [31:0]  exp_last;
        bank_t        exp_data;
        logic         exp_err;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         iob_pric;
    logic         l2c_datain_vld;
    logic         l2c_datain_last;
    logic         l2c_datain_rdy;
    logic [255:0] l2c_datain_data;
    bank_t        CU_bank_data_in;
    logic [31:0]  CU_bank_data_in_vld;
    logic [31:0]  CU_bank_data_in_last;
    logic [31:0]  CU_bank_data_in_ready;
    logic         odd_last_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    iob_scatter dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .iob_pric              (iob_pric),
        .l2c_datain_vld        (l2c_datain_vld),
        .l2c_datain_last       (l2c_datain_last),
        .l2c_datain_rdy        (l2c_datain_rdy),
        .l2c_datain_data       (l2c_datain_data),
        .CU_bank_data_in       (CU_bank_data_in),
        .CU_bank_data_in_vld   (CU_bank_data_in_vld),
        .CU_bank_data_in_last  (CU_bank_data_in_last),
        .CU_bank_data_in_ready (CU_bank_data_in_ready),
        .odd_last_err          (odd_last_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_data(input string name, input bank_t act, input bank_t exp);
        int bad;
        bad = -1;
        n_checks++;
        for (int j = 0; j < 32; j++) begin
            if (bad < 0 && act[j] !== exp[j]) bad = j;
        end
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s: lane %0d got %h expected %h", name, bad, act[bad], exp[bad]);
        end
    endtask

    function automatic logic [255:0] beat8(input int base);
        logic [255:0] b;
        for (int j = 0; j < 32; j++) b[8*j +: 8] = 8'(base + j);
        return b;
    endfunction

    function automatic logic [255:0] beat16(input int base);
        logic [255:0] b;
        for (int k = 0; k < 16; k++) b[16*k +: 16] = 16'(base + k);
        return b;
    endfunction

    // Expected int8 lanes from a byte-ramp beat: lane j holds (base+j) mod 256.
    function automatic bank_t ramp8(input int base);
        bank_t e;
        for (int j = 0; j < 32; j++) e[j] = 32'((base + j) % 256);
        return e;
    endfunction

    // Expected int16 lanes from two halfword-ramp beats; hi_base < 0 means upper banks empty.
    function automatic bank_t ramp16(input int lo_base, input int hi_base);
        bank_t e;
        for (int j = 0; j < 32; j++) begin
            if (j < 16)            e[j] = 32'(lo_base + j);
            else if (hi_base >= 0) e[j] = 32'(hi_base + j - 16);
            else                   e[j] = 32'd0;
        end
        return e;
    endfunction

    function automatic bank_t m_pack8(input logic [255:0] d);
        bank_t e;
        for (int j = 0; j < 32; j++) e[j] = {24'h0, d[8*j +: 8]};
        return e;
    endfunction

    function automatic bank_t m_pack16(input logic [255:0] lo, input logic [255:0] hi, input bit with_hi);
        bank_t e;
        for (int j = 0; j < 32; j++) begin
            if (j < 16)       e[j] = {16'h0, lo[16*j +: 16]};
            else if (with_hi) e[j] = {16'h0, hi[16*(j-16) +: 16]};
            else              e[j] = 32'd0;
        end
        return e;
    endfunction

    task automatic drive(input logic v, input logic p, input logic l, input logic [255:0] d);
        l2c_datain_vld  = v;
        iob_pric        = p;
        l2c_datain_last = l;
        l2c_datain_data = d;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 256'h0);
        CU_bank_data_in_ready = '1;
        rst_n = 1'b0;
        #3;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    vec_t tbl [10];

    initial begin
        bit           m_pend, m_half, m_err, m_fire, m_in_fire, exp_rdy;
        logic [31:0]  m_vld, m_last;
        bank_t        m_data;
        logic [255:0] m_stage, rd;
        int           n_out;

        rst_n = 1'b1;
        CU_bank_data_in_ready = '1;
        drive(1'b0, 1'b0, 1'b0, 256'h0);
        #2 rst_n = 1'b0;
        #2;
        chk("reset_vld", CU_bank_data_in_vld, 32'h0);
        chk("reset_last", CU_bank_data_in_last, 32'h0);
        chk_data("reset_data", CU_bank_data_in, '0);
        chk("reset_err", {31'h0, odd_last_err}, 32'h0);
        chk("reset_rdy", {31'h0, l2c_datain_rdy}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ---------------- vector table ----------------
        for (int i = 0; i < 4; i++) begin
            tbl[i] = '{1'b0, (i == 3), beat8(16*i), 32'hFFFFFFFF,
                       (i == 3) ? 32'hFFFFFFFF : 32'h0, ramp8(16*i), 1'b0};
        end
        tbl[4] = '{1'b1, 1'b0, beat16(16'h1000), 32'h0, 32'h0, '0, 1'b0};
        tbl[5] = '{1'b1, 1'b1, beat16(16'h2000), 32'hFFFFFFFF, 32'hFFFFFFFF, ramp16(16'h1000, 16'h2000), 1'b0};
        tbl[6] = '{1'b1, 1'b0, beat16(16'h3000), 32'h0, 32'h0, '0, 1'b0};
        tbl[7] = '{1'b1, 1'b0, beat16(16'h4000), 32'hFFFFFFFF, 32'h0, ramp16(16'h3000, 16'h4000), 1'b0};
        tbl[8] = '{1'b1, 1'b1, beat16(16'h5000), 32'h0000FFFF, 32'h0000FFFF, ramp16(16'h5000, -1), 1'b1};
        tbl[9] = '{1'b0, 1'b1, beat8(8'h80), 32'hFFFFFFFF, 32'hFFFFFFFF, ramp8(8'h80), 1'b0};

        for (int i = 0; i < 10; i++) begin
            drive(1'b1, tbl[i].pric, tbl[i].last, tbl[i].data);
            @(negedge clk);
            chk($sformatf("tbl%0d_rdy", i), {31'h0, l2c_datain_rdy}, 32'h1);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_vld", i), CU_bank_data_in_vld, tbl[i].exp_vld);
            chk($sformatf("tbl%0d_last", i), CU_bank_data_in_last, tbl[i].exp_last);
            chk($sformatf("tbl%0d_err", i), {31'h0, odd_last_err}, {31'h0, tbl[i].exp_err});
            if (tbl[i].exp_vld != 32'h0) chk_data($sformatf("tbl%0d_data", i), CU_bank_data_in, tbl[i].exp_data);
        end
        drive(1'b0, 1'b0, 1'b0, 256'h0);
        @(posedge clk);
        #1;
        chk("tbl_drain_vld", CU_bank_data_in_vld, 32'h0);

        // ---------------- backpressure: bank 7 stalls five cycles ----------------
        CU_bank_data_in_ready = ~32'h80;
        drive(1'b1, 1'b0, 1'b0, beat8(8'h40));
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 1'b1, beat8(8'h60));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_rdy%0d", i), {31'h0, l2c_datain_rdy}, 32'h0);
            chk($sformatf("bp_vld%0d", i), CU_bank_data_in_vld, 32'hFFFFFFFF);
            chk_data($sformatf("bp_hold%0d", i), CU_bank_data_in, ramp8(8'h40));
            @(posedge clk);
            #1;
        end
        CU_bank_data_in_ready = '1;
        @(negedge clk);
        chk("bp_release_rdy", {31'h0, l2c_datain_rdy}, 32'h1);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 256'h0);
        chk_data("bp_next_data", CU_bank_data_in, ramp8(8'h60));
        chk("bp_next_last", CU_bank_data_in_last, 32'hFFFFFFFF);
        @(posedge clk);
        #1;
        chk("bp_no_dup", CU_bank_data_in_vld, 32'h0);

        // ---------------- odd-last output with upper banks not ready ----------------
        CU_bank_data_in_ready = 32'h0000FFFF;
        drive(1'b1, 1'b1, 1'b1, beat16(16'h7000));
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 256'h0);
        chk("odd_vld", CU_bank_data_in_vld, 32'h0000FFFF);
        chk("odd_err", {31'h0, odd_last_err}, 32'h1);
        chk_data("odd_data", CU_bank_data_in, ramp16(16'h7000, -1));
        @(negedge clk);
        chk("odd_rdy", {31'h0, l2c_datain_rdy}, 32'h1);
        @(posedge clk);
        #1;
        chk("odd_fired", CU_bank_data_in_vld, 32'h0);
        chk("odd_err_pulse", {31'h0, odd_last_err}, 32'h0);
        CU_bank_data_in_ready = '1;

        // ---------------- mode toggle in HALF, then reset in HALF ----------------
        drive(1'b1, 1'b1, 1'b0, beat16(16'h0100));
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 1'b1, beat16(16'h0200));
        @(posedge clk);
        #1;
        drive(1'b1, 1'b1, 1'b0, beat16(16'h0300));
        chk("mode_vld", CU_bank_data_in_vld, 32'hFFFFFFFF);
        chk_data("mode_data", CU_bank_data_in, ramp16(16'h0100, 16'h0200));
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 256'h0);
        rst_n = 1'b0;
        #2;
        chk("rst_half_vld", CU_bank_data_in_vld, 32'h0);
        chk("rst_half_last", CU_bank_data_in_last, 32'h0);
        chk_data("rst_half_data", CU_bank_data_in, '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 1'b1, beat8(8'h20));
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 256'h0);
        chk("rst_restart_vld", CU_bank_data_in_vld, 32'hFFFFFFFF);
        chk_data("rst_restart_data", CU_bank_data_in, ramp8(8'h20));

        // ---------------- randomized traffic vs reference model ----------------
        do_reset();
        m_pend = 0; m_half = 0; m_err = 0;
        m_vld = '0; m_last = '0; m_data = '0; m_stage = '0;
        n_out = 0;
        for (int c = 0; c < 800; c++) begin
            for (int w = 0; w < 8; w++) rd[32*w +: 32] = $urandom;
            drive(($urandom_range(3) != 0), 1'($urandom_range(1)), ($urandom_range(3) == 0), rd);
            if ($urandom_range(3) == 0) CU_bank_data_in_ready = $urandom | $urandom | $urandom;
            else                        CU_bank_data_in_ready = '1;
            @(negedge clk);
            m_fire  = m_pend && (&(CU_bank_data_in_ready | ~m_vld));
            exp_rdy = !m_pend || m_fire;
            chk("rnd_rdy", {31'h0, l2c_datain_rdy}, {31'h0, exp_rdy});
            chk("rnd_err", {31'h0, odd_last_err}, {31'h0, m_err});
            if (m_pend) begin
                chk("rnd_vld", CU_bank_data_in_vld, m_vld);
                chk("rnd_last", CU_bank_data_in_last, m_last);
                chk_data("rnd_data", CU_bank_data_in, m_data);
            end else begin
                chk("rnd_idle_vld", CU_bank_data_in_vld, 32'h0);
            end
            m_in_fire = l2c_datain_vld && exp_rdy;
            m_err = 0;
            if (m_fire) begin
                m_pend = 0;
                n_out++;
            end
            if (m_in_fire) begin
                if (m_half) begin
                    m_pend = 1; m_half = 0;
                    m_data = m_pack16(m_stage, l2c_datain_data, 1);
                    m_vld  = '1;
                    m_last = {32{l2c_datain_last}};
                end else if (!iob_pric) begin
                    m_pend = 1;
                    m_data = m_pack8(l2c_datain_data);
                    m_vld  = '1;
                    m_last = {32{l2c_datain_last}};
                end else if (l2c_datain_last) begin
                    m_pend = 1; m_err = 1;
                    m_data = m_pack16(l2c_datain_data, 256'h0, 0);
                    m_vld  = 32'h0000FFFF;
                    m_last = 32'h0000FFFF;
                end else begin
                    m_half  = 1;
                    m_stage = l2c_datain_data;
                end
            end
            @(posedge clk);
            #1;
        end
        chk("rnd_outputs_seen", (n_out > 100) ? 32'h1 : 32'h0, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
